// File: rtl/cpu_run_if.sv
// Bundles the run-control request/status signals between the top level and the run controller.
interface cpu_run_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
);
  logic             start;
  logic [XLEN-1:0]  pc;
  logic [31:0]      instr;
  logic             retire;
  logic             cpu_rst;
  logic             cpu_hold;
  logic [CNT_W-1:0] run_cycles;
  logic [CNT_W-1:0] retired_count;
  logic             done;
  logic [1:0]       status;
  logic [XLEN-1:0]  halt_pc;

  modport master (
    output start, pc, instr, retire,
    input  cpu_rst, cpu_hold, run_cycles, retired_count, done, status, halt_pc
  );

  modport slave (
    input  start, pc, instr, retire,
    output cpu_rst, cpu_hold, run_cycles, retired_count, done, status, halt_pc
  );
endinterface

// File: rtl/cpu_run_controller.sv
// Run controller for the femtoRV32 cores: sequences core reset, bounds the run with a
// cycle budget and reports halt / stall / timeout status.
//
// state | meaning
// IDLE  | core held in reset and frozen, waiting for start
// RESET | core reset asserted for RST_CYCLES cycles, clock enabled
// RUN   | core running; counters advance, terminations evaluated
// DONE  | core frozen out of reset, status valid
module cpu_run_controller #(
  parameter int XLEN        = 32,
  parameter int CNT_W       = 32,
  parameter int RST_CYCLES  = 2,
  parameter int RUN_CYCLES  = 51,
  parameter int STALL_LIMIT = 8
) (
  input logic     clk,
  input logic     rst,
  cpu_run_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RESET, RUN, DONE} state_t;

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [1:0]  ST_NONE    = 2'd0;
  localparam logic [1:0]  ST_HALT    = 2'd1;
  localparam logic [1:0]  ST_TIMEOUT = 2'd2;
  localparam logic [1:0]  ST_STALL   = 2'd3;

  state_t           state;
  logic [31:0]      rst_cnt;
  logic [XLEN-1:0]  prev_pc;
  logic             prev_valid;
  logic [31:0]      stall_cnt;
  logic             cpu_rst_q, cpu_hold_q, done_q;
  logic [1:0]       status_q;
  logic [CNT_W-1:0] run_cycles_q, retired_q;
  logic [XLEN-1:0]  halt_pc_q;

  logic [CNT_W-1:0] cyc_inc, ret_inc;
  logic [31:0]      stall_nxt;
  logic             is_halt, is_stall, is_timeout;

  always_comb begin
    cyc_inc    = (run_cycles_q == '1) ? run_cycles_q : run_cycles_q + CNT_W'(1);
    ret_inc    = (retired_q == '1) ? retired_q : retired_q + CNT_W'(1);
    stall_nxt  = (prev_valid && (bus.pc == prev_pc)) ? stall_cnt + 32'd1 : 32'd0;
    is_halt    = bus.retire && ((bus.instr == ECALL) || (bus.instr == EBREAK));
    is_stall   = (STALL_LIMIT != 0) && (stall_nxt == 32'(STALL_LIMIT));
    is_timeout = (cyc_inc == CNT_W'(RUN_CYCLES));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      rst_cnt      <= '0;
      prev_pc      <= '0;
      prev_valid   <= 1'b0;
      stall_cnt    <= '0;
      cpu_rst_q    <= 1'b1;
      cpu_hold_q   <= 1'b1;
      done_q       <= 1'b0;
      status_q     <= ST_NONE;
      run_cycles_q <= '0;
      retired_q    <= '0;
      halt_pc_q    <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state        <= RESET;
            rst_cnt      <= 32'(RST_CYCLES - 1);
            cpu_rst_q    <= 1'b1;
            cpu_hold_q   <= 1'b0;
            done_q       <= 1'b0;
            status_q     <= ST_NONE;
            run_cycles_q <= '0;
            retired_q    <= '0;
            halt_pc_q    <= '0;
          end
        end
        RESET: begin
          if (rst_cnt == 32'd0) begin
            state      <= RUN;
            cpu_rst_q  <= 1'b0;
            prev_valid <= 1'b0;
            stall_cnt  <= '0;
          end else begin
            rst_cnt <= rst_cnt - 32'd1;
          end
        end
        RUN: begin
          run_cycles_q <= cyc_inc;
          if (bus.retire) retired_q <= ret_inc;
          prev_pc    <= bus.pc;
          prev_valid <= 1'b1;
          stall_cnt  <= stall_nxt;
          if (is_halt || is_stall || is_timeout) begin
            state      <= DONE;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b1;
            halt_pc_q  <= bus.pc;
            status_q   <= is_halt ? ST_HALT : (is_stall ? ST_STALL : ST_TIMEOUT);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cpu_rst       = cpu_rst_q;
  assign bus.cpu_hold      = cpu_hold_q;
  assign bus.done          = done_q;
  assign bus.status        = status_q;
  assign bus.run_cycles    = run_cycles_q;
  assign bus.retired_count = retired_q;
  assign bus.halt_pc       = halt_pc_q;
endmodule

// File: tb/tb_cpu_run_controller.sv
// Directed self-checking bench for cpu_run_controller.
module tb_cpu_run_controller;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  localparam logic [31:0] ECALL  = 32'h0000_0073;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  cpu_run_if #(.XLEN(32), .CNT_W(32)) bus ();

  cpu_run_controller #(
    .XLEN(32), .CNT_W(32), .RST_CYCLES(2), .RUN_CYCLES(51), .STALL_LIMIT(8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run_cycle(input logic [31:0] pc, input logic [31:0] ins, input logic ret);
    bus.pc     = pc;
    bus.instr  = ins;
    bus.retire = ret;
    tick();
  endtask

  // start pulse then two RESET cycles; afterwards the core is in its first RUN cycle
  task automatic launch(input string tag);
    bus.start = 1'b1;
    tick();
    check({tag, "_done_drop"}, 64'(bus.done), 64'd0);
    check({tag, "_cnt_clear"}, 64'(bus.run_cycles), 64'd0);
    check({tag, "_rst1"}, 64'(bus.cpu_rst), 64'd1);
    bus.start = 1'b0;
    tick();
    check({tag, "_rst2"}, 64'(bus.cpu_rst), 64'd1);
    tick();
    check({tag, "_run_rst"}, 64'(bus.cpu_rst), 64'd0);
    check({tag, "_run_hold"}, 64'(bus.cpu_hold), 64'd0);
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.pc     = '0;
    bus.instr  = NOP;
    bus.retire = 1'b0;

    // reset and idle
    tick(); tick();
    check("rst_cpu_rst", 64'(bus.cpu_rst), 64'd1);
    check("rst_hold", 64'(bus.cpu_hold), 64'd1);
    check("rst_done", 64'(bus.done), 64'd0);
    rst = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    check("idle_cpu_rst", 64'(bus.cpu_rst), 64'd1);
    check("idle_hold", 64'(bus.cpu_hold), 64'd1);
    check("idle_done", 64'(bus.done), 64'd0);

    // timeout
    launch("to");
    for (int k = 1; k <= 50; k++) run_cycle(32'(4 * k), NOP, 1'b0);
    check("to_not_done_50", 64'(bus.done), 64'd0);
    check("to_cycles_50", 64'(bus.run_cycles), 64'd50);
    run_cycle(32'd204, NOP, 1'b0);
    check("to_done", 64'(bus.done), 64'd1);
    check("to_status", 64'(bus.status), 64'd2);
    check("to_cycles", 64'(bus.run_cycles), 64'd51);
    check("to_halt_pc", 64'(bus.halt_pc), 64'd204);
    check("to_hold", 64'(bus.cpu_hold), 64'd1);
    check("to_cpu_rst", 64'(bus.cpu_rst), 64'd0);
    for (int k = 0; k < 4; k++) run_cycle(32'h500, ECALL, 1'b1);
    check("done_frozen_cycles", 64'(bus.run_cycles), 64'd51);
    check("done_frozen_status", 64'(bus.status), 64'd2);

    // ECALL on the 10th RUN cycle, retiring every cycle
    launch("ec");
    for (int k = 1; k <= 9; k++) run_cycle(32'(32'h100 + 4 * k), NOP, 1'b1);
    check("ec_not_done", 64'(bus.done), 64'd0);
    run_cycle(32'h128, ECALL, 1'b1);
    check("ec_done", 64'(bus.done), 64'd1);
    check("ec_status", 64'(bus.status), 64'd1);
    check("ec_retired", 64'(bus.retired_count), 64'd10);
    check("ec_cycles", 64'(bus.run_cycles), 64'd10);
    check("ec_halt_pc", 64'(bus.halt_pc), 64'h128);

    // pc stuck at 0x40 from RUN cycle 5: eighth repeat is cycle 13
    launch("st");
    for (int k = 1; k <= 4; k++) run_cycle(32'(4 * k), NOP, 1'b0);
    for (int k = 5; k <= 12; k++) run_cycle(32'h40, NOP, 1'b0);
    check("st_not_done", 64'(bus.done), 64'd0);
    run_cycle(32'h40, NOP, 1'b0);
    check("st_status", 64'(bus.status), 64'd3);
    check("st_cycles", 64'(bus.run_cycles), 64'd13);
    check("st_halt_pc", 64'(bus.halt_pc), 64'h40);

    // same stall cycle with EBREAK retiring: halt wins
    launch("sp");
    for (int k = 1; k <= 4; k++) run_cycle(32'(4 * k), NOP, 1'b0);
    for (int k = 5; k <= 12; k++) run_cycle(32'h40, NOP, 1'b0);
    run_cycle(32'h40, EBREAK, 1'b1);
    check("sp_status", 64'(bus.status), 64'd1);
    check("sp_retired", 64'(bus.retired_count), 64'd1);
    check("sp_cycles", 64'(bus.run_cycles), 64'd13);

    // EBREAK on the budget's last cycle: halt beats timeout
    launch("tp");
    for (int k = 1; k <= 50; k++) run_cycle(32'(4 * k), NOP, 1'b0);
    run_cycle(32'd204, EBREAK, 1'b1);
    check("tp_status", 64'(bus.status), 64'd1);
    check("tp_cycles", 64'(bus.run_cycles), 64'd51);

    // async reset mid-run at RUN cycle 20
    launch("ab");
    for (int k = 1; k <= 19; k++) run_cycle(32'(4 * k), NOP, 1'b1);
    check("ab_cycles_19", 64'(bus.run_cycles), 64'd19);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("ab_cpu_rst", 64'(bus.cpu_rst), 64'd1);
    check("ab_hold", 64'(bus.cpu_hold), 64'd1);
    check("ab_cycles", 64'(bus.run_cycles), 64'd0);
    check("ab_retired", 64'(bus.retired_count), 64'd0);
    check("ab_done", 64'(bus.done), 64'd0);
    check("ab_status", 64'(bus.status), 64'd0);
    tick();
    rst = 1'b1;
    tick(); tick();
    check("ab_idle_rst", 64'(bus.cpu_rst), 64'd1);
    check("ab_idle_done", 64'(bus.done), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
